vga_text_console: RTL and testbench
===================================

// Module: vga_text_console
// PURPOSE
//  Terminal-style write sequencer for the VGA character display (64x24 cells of 10x20 px).
//  Accepts a byte stream with a valid/ready handshake and tracks the cursor and current colours.
//  Drives the display's charWr* write port, one cell per cycle.
//  Handles control codes, line wrap and line/screen clears. VRAM is write-only here, so there is no scrolling.
// PARAMETERS
//  COLS        64         cells per row; charWrX range 0..COLS-1
//  ROWS        24         rows per screen; charWrY range 0..ROWS-1
//  DEFAULT_FG  24'hFFFFFF foreground colour after reset
//  DEFAULT_BG  24'h000000 background colour after reset
//  CLEAR_CODE  8'h20      glyph code written by clears and backspace
// PORTS
//  CLOCK_50       in   1   system clock; all state changes on rising edge
//  RESET_N        in   1   asynchronous, active-low reset
//  inValid        in   1   inByte valid
//  inByte         in   8   character or control code
//  inReady        out  1   high only in IDLE; byte accepted when inValid & inReady at a rising edge
//  colorWr        in   1   load colour registers (accepted in any state)
//  colorFg        in   24  new foreground colour
//  colorBg        in   24  new background colour
//  charWr         out  1   cell write strobe to the display
//  charWrFgColor  out  24  foreground colour of written cell
//  charWrBgColor  out  24  background colour of written cell
//  charWrCode     out  8   glyph code of written cell
//  charWrX        out  6   write column
//  charWrY        out  5   write row
//  cursorX        out  6   current cursor column
//  cursorY        out  5   current cursor row
//  busy           out  1   high in CLR_LINE or CLR_SCREEN
// BEHAVIOUR
//  Reset:
//   - All charWr* outputs 0; cursor (0,0); colours DEFAULT_FG/DEFAULT_BG; state CLR_SCREEN.
//   - Reset asserted mid-operation abandons the operation and restarts the full clear.
//  Outputs:
//   - All outputs except inReady are registered.
//   - A byte accepted at edge k produces its charWr pulse in the cycle after edge k (latency 1).
//   - charWr is high for exactly one cycle per cell write.
//  States:
//   - IDLE: inReady=1.
//   - CLR_LINE: clearing the cursor row.
//   - CLR_SCREEN: clearing the whole screen.
//  Clears:
//   - Each cycle write (clrX, row) with CLEAR_CODE in the current colours.
//   - clrX counts 0..COLS-1.
//   - CLR_SCREEN steps rows 0..ROWS-1 row-major, taking exactly COLS*ROWS = 1536 cycles.
//   - CLR_LINE takes exactly COLS = 64 cycles.
//   - On the last write, return to IDLE; inReady rises the following cycle.
//  Byte decode (IDLE, on accept):
//   - 0x20..0xFF: write inByte at the cursor, then X+1. At X=COLS-1 instead do NEWLINE.
//   - 0x0A LF: NEWLINE.
//   - 0x0D CR: X=0; no write.
//   - 0x08 BS: if X>0, X-1 and write CLEAR_CODE at the new X; if X=0, no-op (no reverse line wrap).
//   - 0x0C FF: cursor (0,0); enter CLR_SCREEN.
//   - Other codes <0x20: accepted and ignored; no write.
//  NEWLINE:
//   - X=0; Y+1, with Y=ROWS-1 wrapping to Y=0.
//   - Enter CLR_LINE on the new row, so stale text never remains under the cursor row.
//  Colours:
//   - colorWr loads both colour registers at the edge.
//   - A byte accepted on the same edge still uses the old colours.
//   - A clear in progress switches to the new colours from the next cell.
//  Arithmetic:
//   - Cursor and clear counters are unsigned and compare against COLS-1/ROWS-1.
//   - They never reach COLS or ROWS.
// TESTING
//  T1 reset:
//   - Release RESET_N -> 1536 consecutive charWr pulses, code 8'h20, fg FFFFFF, bg 000000.
//   - Cells (0,0),(1,0)..(63,23) in order; then inReady=1; cursor (0,0).
//  T2 print:
//   - Send 'A','B' (0x41,0x42) -> writes (0,0)=41 and (1,0)=42, one cycle after each accept; cursor (2,0).
//  T3 wrap:
//   - Cursor (63,5), send 0x5A -> write (63,5)=5A.
//   - Then 64 clears of row 6, busy=1, inReady=0; cursor (0,6).
//  T4 bottom wrap:
//   - Cursor (10,23), send 0x0A -> cursor (0,0); row 0 cleared in 64 cycles.
//  T5 backspace:
//   - At (3,2) send 0x08 -> write (2,2)=20; cursor (2,2).
//   - At (0,2) send 0x08 -> no write; cursor unchanged.
//  T6 colour/reset:
//   - colorWr with fg 0000FF and a byte on the same edge -> byte uses old fg; next byte uses 0000FF.
//   - Assert RESET_N during CLR_SCREEN -> outputs 0 immediately; full clear restarts at (0,0).

Source files
------------

// File: rtl/vga_text_console.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_console
// Description : Terminal-style write sequencer for a 64x24 character display.
//               Accepts bytes on a valid/ready handshake, tracks the cursor
//               and colours, and emits one cell write per cycle, including
//               line and full-screen clears.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_text_console #(
    parameter int          COLS       = 64,
    parameter int          ROWS       = 24,
    parameter logic [23:0] DEFAULT_FG = 24'hFFFFFF,
    parameter logic [23:0] DEFAULT_BG = 24'h000000,
    parameter logic [7:0]  CLEAR_CODE = 8'h20
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        inValid,
    input  logic [7:0]  inByte,
    output logic        inReady,
    input  logic        colorWr,
    input  logic [23:0] colorFg,
    input  logic [23:0] colorBg,
    output logic        charWr,
    output logic [23:0] charWrFgColor,
    output logic [23:0] charWrBgColor,
    output logic [7:0]  charWrCode,
    output logic [5:0]  charWrX,
    output logic [4:0]  charWrY,
    output logic [5:0]  cursorX,
    output logic [4:0]  cursorY,
    output logic        busy
);

    localparam logic [5:0] LAST_X = 6'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_CLR_LINE   = 2'd1,
        S_CLR_SCREEN = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [5:0]  cursor_x_q, cursor_x_d;
    logic [4:0]  cursor_y_q, cursor_y_d;
    logic [5:0]  clr_x_q,    clr_x_d;
    logic [4:0]  clr_y_q,    clr_y_d;
    logic [23:0] fg_q,       fg_d;
    logic [23:0] bg_q,       bg_d;
    logic        wr_q,       wr_d;
    logic [23:0] wr_fg_q,    wr_fg_d;
    logic [23:0] wr_bg_q,    wr_bg_d;
    logic [7:0]  wr_code_q,  wr_code_d;
    logic [5:0]  wr_x_q,     wr_x_d;
    logic [4:0]  wr_y_q,     wr_y_d;
    logic        newline;

    // Next-state logic: byte decode in IDLE, cell sweeps in the clear states
    always_comb begin
        state_d    = state_q;
        cursor_x_d = cursor_x_q;
        cursor_y_d = cursor_y_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        wr_d       = 1'b0;
        wr_fg_d    = wr_fg_q;
        wr_bg_d    = wr_bg_q;
        wr_code_d  = wr_code_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        newline    = 1'b0;

        // Colour load is independent of state; writes this cycle still use
        // the old registers because they read fg_q/bg_q.
        if (colorWr) begin
            fg_d = colorFg;
            bg_d = colorBg;
        end

        case (state_q)
            S_IDLE: begin
                if (inValid) begin
                    if (inByte >= 8'h20) begin
                        wr_d      = 1'b1;
                        wr_code_d = inByte;
                        wr_x_d    = cursor_x_q;
                        wr_y_d    = cursor_y_q;
                        wr_fg_d   = fg_q;
                        wr_bg_d   = bg_q;
                        if (cursor_x_q == LAST_X) begin
                            newline = 1'b1;
                        end else begin
                            cursor_x_d = cursor_x_q + 6'd1;
                        end
                    end else if (inByte == 8'h0A) begin
                        newline = 1'b1;
                    end else if (inByte == 8'h0D) begin
                        cursor_x_d = 6'd0;
                    end else if (inByte == 8'h08) begin
                        // No reverse wrap: backspace at column 0 does nothing
                        if (cursor_x_q != 6'd0) begin
                            cursor_x_d = cursor_x_q - 6'd1;
                            wr_d       = 1'b1;
                            wr_code_d  = CLEAR_CODE;
                            wr_x_d     = cursor_x_q - 6'd1;
                            wr_y_d     = cursor_y_q;
                            wr_fg_d    = fg_q;
                            wr_bg_d    = bg_q;
                        end
                    end else if (inByte == 8'h0C) begin
                        cursor_x_d = 6'd0;
                        cursor_y_d = 5'd0;
                        clr_x_d    = 6'd0;
                        clr_y_d    = 5'd0;
                        state_d    = S_CLR_SCREEN;
                    end
                end
            end
            S_CLR_LINE: begin
                wr_d      = 1'b1;
                wr_code_d = CLEAR_CODE;
                wr_x_d    = clr_x_q;
                wr_y_d    = cursor_y_q;
                wr_fg_d   = fg_q;
                wr_bg_d   = bg_q;
                if (clr_x_q == LAST_X) begin
                    clr_x_d = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    clr_x_d = clr_x_q + 6'd1;
                end
            end
            S_CLR_SCREEN: begin
                wr_d      = 1'b1;
                wr_code_d = CLEAR_CODE;
                wr_x_d    = clr_x_q;
                wr_y_d    = clr_y_q;
                wr_fg_d   = fg_q;
                wr_bg_d   = bg_q;
                if (clr_x_q == LAST_X) begin
                    clr_x_d = 6'd0;
                    if (clr_y_q == LAST_Y) begin
                        clr_y_d = 5'd0;
                        state_d = S_IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 5'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 6'd1;
                end
            end
            default: state_d = S_CLR_SCREEN;
        endcase

        // Newline moves to the next row (wrapping to the top) and wipes it
        if (newline) begin
            cursor_x_d = 6'd0;
            cursor_y_d = (cursor_y_q == LAST_Y) ? 5'd0 : cursor_y_q + 5'd1;
            clr_x_d    = 6'd0;
            state_d    = S_CLR_LINE;
        end
    end

    // State and output registers; reset restarts the full-screen clear
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_CLR_SCREEN;
            cursor_x_q <= 6'd0;
            cursor_y_q <= 5'd0;
            clr_x_q    <= 6'd0;
            clr_y_q    <= 5'd0;
            fg_q       <= DEFAULT_FG;
            bg_q       <= DEFAULT_BG;
            wr_q       <= 1'b0;
            wr_fg_q    <= 24'd0;
            wr_bg_q    <= 24'd0;
            wr_code_q  <= 8'd0;
            wr_x_q     <= 6'd0;
            wr_y_q     <= 5'd0;
        end else begin
            state_q    <= state_d;
            cursor_x_q <= cursor_x_d;
            cursor_y_q <= cursor_y_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            fg_q       <= fg_d;
            bg_q       <= bg_d;
            wr_q       <= wr_d;
            wr_fg_q    <= wr_fg_d;
            wr_bg_q    <= wr_bg_d;
            wr_code_q  <= wr_code_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
        end
    end

    assign inReady       = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign charWr        = wr_q;
    assign charWrFgColor = wr_fg_q;
    assign charWrBgColor = wr_bg_q;
    assign charWrCode    = wr_code_q;
    assign charWrX       = wr_x_q;
    assign charWrY       = wr_y_q;
    assign cursorX       = cursor_x_q;
    assign cursorY       = cursor_y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_console
// Description : Scoreboard bench for vga_text_console. Stimulus pushes the
//               expected cell writes (with the cycle they must appear in);
//               a monitor pops and compares on every charWr pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_text_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        color_wr = 1'b0;
    logic [23:0] color_fg = 24'd0;
    logic [23:0] color_bg = 24'd0;
    logic        char_wr;
    logic [23:0] wr_fg, wr_bg;
    logic [7:0]  wr_code;
    logic [5:0]  wr_x;
    logic [4:0]  wr_y;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] BLUE  = 24'h0000FF;

    vga_text_console dut (
        .CLOCK_50      (clk),
        .RESET_N       (rst_n),
        .inValid       (in_valid),
        .inByte        (in_byte),
        .inReady       (in_ready),
        .colorWr       (color_wr),
        .colorFg       (color_fg),
        .colorBg       (color_bg),
        .charWr        (char_wr),
        .charWrFgColor (wr_fg),
        .charWrBgColor (wr_bg),
        .charWrCode    (wr_code),
        .charWrX       (wr_x),
        .charWrY       (wr_y),
        .cursorX       (cur_x),
        .cursorY       (cur_y),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [5:0]  x;
        logic [4:0]  y;
        logic [23:0] fg;
        logic [23:0] bg;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Cycle counter: a write registered at edge N is observed while cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every charWr pulse must match the oldest expected write
    always @(negedge clk) begin
        if (char_wr) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got code=%h (%0d,%0d) at cyc %0d, none expected",
                         wr_code, wr_x, wr_y, cyc);
            end else begin
                mon_e = q.pop_front();
                if (wr_code !== mon_e.code || wr_x !== mon_e.x || wr_y !== mon_e.y ||
                    wr_fg !== mon_e.fg || wr_bg !== mon_e.bg || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL cell_write: got code=%h (%0d,%0d) fg=%h bg=%h cyc=%0d, required code=%h (%0d,%0d) fg=%h bg=%h cyc=%0d",
                             wr_code, wr_x, wr_y, wr_fg, wr_bg, cyc,
                             mon_e.code, mon_e.x, mon_e.y, mon_e.fg, mon_e.bg, mon_e.due);
                end
            end
        end
    end

    task automatic push(input logic [7:0] code, input int x, input int y,
                        input logic [23:0] fg, input logic [23:0] bg, input int due);
        exp_t e;
        e.code = code; e.x = 6'(x); e.y = 5'(y); e.fg = fg; e.bg = bg; e.due = due;
        q.push_back(e);
    endtask

    task automatic push_row(input int y, input logic [23:0] fg, input int due0);
        for (int i = 0; i < 64; i++) push(8'h20, i, y, fg, BLACK, due0 + i);
    endtask

    task automatic push_screen(input logic [23:0] fg, input int due0);
        for (int r = 0; r < 24; r++) push_row(r, fg, due0 + r * 64);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (in_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got inReady=0 after 3000 cycles, required 1");
        end
    endtask

    // Sends one byte; d returns the cycle in which its write (if any) appears
    task automatic send(input logic [7:0] b, input bit cw, input logic [23:0] cfg, output int d);
        wait_idle();
        in_valid = 1'b1;
        in_byte  = b;
        color_wr = cw;
        color_fg = cfg;
        color_bg = BLACK;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        color_wr = 1'b0;
        d = cyc;
    endtask

    int d;

    initial begin
        // T1: reset state, then full clear in default colours
        repeat (3) @(negedge clk);
        check("reset_charWr", 32'(char_wr), 32'd0);
        check("reset_code", 32'(wr_code), 32'd0);
        check("reset_fg", 32'(wr_fg), 32'd0);
        check("reset_cursor", {cur_x, cur_y}, 32'd0);
        check("reset_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        push_screen(WHITE, cyc + 1);
        wait_idle();
        check("t1_cursor", {cur_x, cur_y}, 32'd0);

        // T2: two printable characters
        send(8'h41, 1'b0, BLACK, d); push(8'h41, 0, 0, WHITE, BLACK, d);
        send(8'h42, 1'b0, BLACK, d); push(8'h42, 1, 0, WHITE, BLACK, d);
        @(negedge clk);
        check("t2_cursor", {cur_x, cur_y}, {6'd2, 5'd0});

        // T3: move to (63,5), then a character that wraps the line
        send(8'h0D, 1'b0, BLACK, d);
        for (int r = 1; r <= 5; r++) begin
            send(8'h0A, 1'b0, BLACK, d); push_row(r, WHITE, d + 1);
        end
        for (int i = 0; i < 63; i++) begin
            send(8'(8'h21 + i), 1'b0, BLACK, d); push(8'(8'h21 + i), i, 5, WHITE, BLACK, d);
        end
        send(8'h5A, 1'b0, BLACK, d);
        push(8'h5A, 63, 5, WHITE, BLACK, d);
        push_row(6, WHITE, d + 1);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_cursor", {cur_x, cur_y}, {6'd0, 5'd6});

        // T4: walk to (10,23), then LF wraps to the top row
        for (int r = 7; r <= 23; r++) begin
            send(8'h0A, 1'b0, BLACK, d); push_row(r, WHITE, d + 1);
        end
        for (int i = 0; i < 10; i++) begin
            send(8'(8'h61 + i), 1'b0, BLACK, d); push(8'(8'h61 + i), i, 23, WHITE, BLACK, d);
        end
        send(8'h0A, 1'b0, BLACK, d);
        push_row(0, WHITE, d + 1);
        check("t4_cursor", {cur_x, cur_y}, 32'd0);

        // T5: backspace at (3,2) and at column 0
        for (int r = 1; r <= 2; r++) begin
            send(8'h0A, 1'b0, BLACK, d); push_row(r, WHITE, d + 1);
        end
        for (int i = 0; i < 3; i++) begin
            send(8'h58, 1'b0, BLACK, d); push(8'h58, i, 2, WHITE, BLACK, d);
        end
        send(8'h08, 1'b0, BLACK, d); push(8'h20, 2, 2, WHITE, BLACK, d);
        check("t5_bs_cursor", {cur_x, cur_y}, {6'd2, 5'd2});
        send(8'h0D, 1'b0, BLACK, d);
        send(8'h08, 1'b0, BLACK, d);
        repeat (3) @(negedge clk);
        check("t5_bs0_cursor", {cur_x, cur_y}, {6'd0, 5'd2});

        // T6: colour load on the same edge as a byte, then reset mid-clear
        send(8'h31, 1'b1, BLUE, d);  push(8'h31, 0, 2, WHITE, BLACK, d);
        send(8'h32, 1'b0, BLACK, d); push(8'h32, 1, 2, BLUE, BLACK, d);
        send(8'h0C, 1'b0, BLACK, d); push_screen(BLUE, d + 1);
        check("t6_ff_cursor", {cur_x, cur_y}, 32'd0);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_charWr", 32'(char_wr), 32'd0);
        check("t6_rst_xy", {wr_x, wr_y}, 32'd0);
        check("t6_rst_code_fg", {wr_code, wr_fg}, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd1);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_screen(WHITE, cyc + 1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("t6_cursor", {cur_x, cur_y}, 32'd0);
        check("drain_queue", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
